pong_ctrl: RTL and testbench
============================

PONG_CTRL -- requirements
Module: pong_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 800, visible columns
- HEIGHT, 600, visible rows
- BALL_SIZE, 5, ball extent; ball spans x..x+BALL_SIZE, y..y+BALL_SIZE inclusive
- PADDLE_LENGTH, 30, paddle spans p..p+PADDLE_LENGTH rows inclusive
- PADDLE_WIDTH, 5, paddle column width
- PADDLE_STEP, 4, paddle pixels per frame
- BALL_STEP, 2, ball pixels per axis per frame
- SERVE_FRAMES, 60, frames ball is held before play
- WIN_SCORE, 9, points to win
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, pixel clock; all state updates on rising edge
- rst, in, 1, asynchronous active-high reset
- frame_tick, in, 1, one-cycle pulse per frame
- start, in, 1, begin game / restart after game over
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, in, 1 each, paddle controls; synchronous and debounced upstream
- ball_x, ball_y, out, 10, ball top-left position
- paddle_l, paddle_r, out, 10, paddle top row
- score_l, score_r, out, 4, points
- state, out, 3, IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- game_over, out, 1, high only in OVER
REQ-003 All outputs SHALL be registered.

Function
REQ-004 Derived constants: CX=(WIDTH-BALL_SIZE)/2=397; CY=(HEIGHT-BALL_SIZE)/2=297; PC=(HEIGHT-PADDLE_LENGTH)/2=285; YMAX=HEIGHT-2-BALL_SIZE=593; PMAX=HEIGHT-2-PADDLE_LENGTH=568; XMIN=PADDLE_WIDTH=5; XMAX=WIDTH-PADDLE_WIDTH-2-BALL_SIZE=788.
REQ-005 Internal direction bits dx (1=right) and dy (1=down) SHALL be kept.
REQ-006 IDLE: start=1 -> SERVE; positions held.
REQ-007 SERVE: ball held at (CX,CY); serve counter increments on each frame_tick; on the frame_tick bringing it to SERVE_FRAMES -> PLAY, counter cleared.
REQ-008 Paddle update in SERVE and PLAY, on frame_tick only, evaluated per side:
- up only: p=max(p-PADDLE_STEP, 1)
- down only: p=min(p+PADDLE_STEP, PMAX)
- both or neither: p unchanged
REQ-009 Ball update in PLAY, on frame_tick only; collision checks use pre-update ball and paddle values.
REQ-010 Vertical motion:
- dy=0 and ball_y < 1+BALL_STEP: ball_y=1, dy=1
- dy=1 and ball_y+BALL_STEP > YMAX: ball_y=YMAX, dy=0
- otherwise: ball_y moves by BALL_STEP in direction dy
REQ-011 Left edge, when dx=0 and ball_x < XMIN+BALL_STEP:
- hit if ball_y+BALL_SIZE >= paddle_l and ball_y <= paddle_l+PADDLE_LENGTH: ball_x=XMIN, dx=1
- otherwise: ball_x=XMIN, score_r+1, -> POINT
REQ-012 Right edge, when dx=1 and ball_x+BALL_STEP > XMAX: same as REQ-011 using paddle_r, ball_x=XMAX, dx=0; a miss increments score_l.
REQ-013 Otherwise ball_x moves by BALL_STEP in direction dx.
REQ-014 X and Y updates SHALL occur in the same cycle (corner case: both bounces apply).
REQ-015 POINT lasts exactly one clock:
- ball set to (CX,CY); dx set toward the player who conceded
- -> OVER if either score equals WIN_SCORE, else -> SERVE
REQ-016 OVER: ball and scores held; start=1 -> scores cleared, paddles set to PC, -> SERVE.
REQ-017 start SHALL be ignored in SERVE, PLAY and POINT.
REQ-018 frame_tick arriving in the POINT cycle SHALL be ignored.
REQ-019 Scores SHALL never exceed WIN_SCORE.

Reset
REQ-020 rst=1 SHALL immediately set:
- state=IDLE; ball=(CX,CY); paddles=PC; scores=0
- dx=1, dy=1; serve counter=0; game_over=0
REQ-021 Reset asserted mid-game SHALL discard all progress; there is no partial state.

Verification
REQ-022 Reset, start, 60 frame_ticks -> state=PLAY on 60th tick; ball still (397,297); next tick -> (399,299).
REQ-023 PLAY, btn_l_up held, paddle_l=5 -> 1 after one tick, stays 1; both buttons held -> no change.
REQ-024 dx=1, ball_x=787, ball_y=300, paddle_r=285 -> ball_x=788, dx=0, scores unchanged.
REQ-025 dx=0, ball_x=6, ball_y=100, paddle_l=285 -> POINT one cycle with score_r+1; next cycle ball=(397,297), dx=0, state=SERVE.
REQ-026 score_l=8 and right-side miss -> score_l=9, OVER, game_over=1; start -> scores 0, SERVE; rst mid-PLAY -> IDLE with all reset values.

Source files
------------

// File: rtl/pong_ctrl.sv
// Pong game controller: serve/play/point/game-over sequencing, paddle and ball
// motion on frame ticks, wall and paddle bounces, and scoring.
module pong_ctrl #(
  parameter int WIDTH         = 32'd800,
  parameter int HEIGHT        = 32'd600,
  parameter int BALL_SIZE     = 32'd5,
  parameter int PADDLE_LENGTH = 32'd30,
  parameter int PADDLE_WIDTH  = 32'd5,
  parameter int PADDLE_STEP   = 32'd4,
  parameter int BALL_STEP     = 32'd2,
  parameter int SERVE_FRAMES  = 32'd60,
  parameter int WIN_SCORE     = 32'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l,
  output logic [9:0] paddle_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       game_over
);

  localparam logic [9:0]  CX    = 10'((WIDTH - BALL_SIZE) / 32'd2);
  localparam logic [9:0]  CY    = 10'((HEIGHT - BALL_SIZE) / 32'd2);
  localparam logic [9:0]  PC    = 10'((HEIGHT - PADDLE_LENGTH) / 32'd2);
  localparam logic [10:0] YMAX  = 11'(HEIGHT - 32'd2 - BALL_SIZE);
  localparam logic [10:0] PMAX  = 11'(HEIGHT - 32'd2 - PADDLE_LENGTH);
  localparam logic [10:0] XMIN  = 11'(PADDLE_WIDTH);
  localparam logic [10:0] XMAX  = 11'(WIDTH - PADDLE_WIDTH - 32'd2 - BALL_SIZE);
  localparam logic [10:0] B_SZ  = 11'(BALL_SIZE);
  localparam logic [10:0] B_ST  = 11'(BALL_STEP);
  localparam logic [10:0] P_LEN = 11'(PADDLE_LENGTH);
  localparam logic [10:0] P_ST  = 11'(PADDLE_STEP);
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam int          CW    = $clog2(SERVE_FRAMES + 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t state_r, state_nx_s;

  logic [9:0]    ball_x_r, ball_y_r, paddle_l_r, paddle_r_r;
  logic [9:0]    ball_x_nx_s, ball_y_nx_s, paddle_l_nx_s, paddle_r_nx_s;
  logic [3:0]    score_l_r, score_r_r, score_l_nx_s, score_r_nx_s;
  logic          dx_r, dy_r, dx_nx_s, dy_nx_s;
  logic          game_over_r, game_over_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;

  logic [10:0] bx_s, by_s, pl_s, pr_s;
  logic        at_left_s, at_right_s, hit_l_s, hit_r_s, miss_l_s, miss_r_s, win_s;

  function automatic logic [9:0] paddle_next(input logic [9:0] p, input logic up, input logic dn);
    logic [10:0] pe;
    pe = {1'b0, p};
    if (up && !dn) begin
      if (pe < P_ST + 11'd1) paddle_next = 10'd1;
      else                   paddle_next = 10'(pe - P_ST);
    end else if (dn && !up) begin
      if (pe + P_ST > PMAX) paddle_next = PMAX[9:0];
      else                  paddle_next = 10'(pe + P_ST);
    end else begin
      paddle_next = p;
    end
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    if (s >= WIN) score_inc = WIN;
    else          score_inc = s + 4'd1;
  endfunction

  // Collision tests always use the pre-update ball and paddle positions.
  assign bx_s       = {1'b0, ball_x_r};
  assign by_s       = {1'b0, ball_y_r};
  assign pl_s       = {1'b0, paddle_l_r};
  assign pr_s       = {1'b0, paddle_r_r};
  assign at_left_s  = !dx_r && (bx_s < XMIN + B_ST);
  assign at_right_s = dx_r && (bx_s + B_ST > XMAX);
  assign hit_l_s    = (by_s + B_SZ >= pl_s) && (by_s <= pl_s + P_LEN);
  assign hit_r_s    = (by_s + B_SZ >= pr_s) && (by_s <= pr_s + P_LEN);
  assign miss_l_s   = at_left_s && !hit_l_s;
  assign miss_r_s   = at_right_s && !hit_r_s;
  assign win_s      = (score_l_r == WIN) || (score_r_r == WIN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nx_s = SERVE; else state_nx_s = IDLE;
      SERVE:   if (frame_tick && cnt_r == CNT_LAST) state_nx_s = PLAY; else state_nx_s = SERVE;
      PLAY:    if (frame_tick && (miss_l_s || miss_r_s)) state_nx_s = POINT; else state_nx_s = PLAY;
      POINT:   if (win_s) state_nx_s = OVER; else state_nx_s = SERVE;
      OVER:    if (start) state_nx_s = SERVE; else state_nx_s = OVER;
      default: state_nx_s = IDLE;
    endcase
  end

  // Next values for the registered game outputs
  always_comb begin
    ball_x_nx_s   = ball_x_r;
    ball_y_nx_s   = ball_y_r;
    paddle_l_nx_s = paddle_l_r;
    paddle_r_nx_s = paddle_r_r;
    score_l_nx_s  = score_l_r;
    score_r_nx_s  = score_r_r;
    dx_nx_s       = dx_r;
    dy_nx_s       = dy_r;
    cnt_nx_s      = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_nx_s = cnt_r;
      end
      SERVE: begin
        ball_x_nx_s = CX;
        ball_y_nx_s = CY;
        if (frame_tick) begin
          paddle_l_nx_s = paddle_next(paddle_l_r, btn_l_up, btn_l_dn);
          paddle_r_nx_s = paddle_next(paddle_r_r, btn_r_up, btn_r_dn);
          if (cnt_r == CNT_LAST) cnt_nx_s = '0;
          else                   cnt_nx_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          paddle_l_nx_s = paddle_next(paddle_l_r, btn_l_up, btn_l_dn);
          paddle_r_nx_s = paddle_next(paddle_r_r, btn_r_up, btn_r_dn);
          if (!dy_r && by_s < B_ST + 11'd1) begin
            ball_y_nx_s = 10'd1;
            dy_nx_s     = 1'b1;
          end else if (dy_r && by_s + B_ST > YMAX) begin
            ball_y_nx_s = YMAX[9:0];
            dy_nx_s     = 1'b0;
          end else if (dy_r) begin
            ball_y_nx_s = 10'(by_s + B_ST);
          end else begin
            ball_y_nx_s = 10'(by_s - B_ST);
          end
          if (at_left_s) begin
            ball_x_nx_s = XMIN[9:0];
            if (hit_l_s) dx_nx_s = 1'b1;
            else         score_r_nx_s = score_inc(score_r_r);
          end else if (at_right_s) begin
            ball_x_nx_s = XMAX[9:0];
            if (hit_r_s) dx_nx_s = 1'b0;
            else         score_l_nx_s = score_inc(score_l_r);
          end else if (dx_r) begin
            ball_x_nx_s = 10'(bx_s + B_ST);
          end else begin
            ball_x_nx_s = 10'(bx_s - B_ST);
          end
        end else begin
          ball_x_nx_s = ball_x_r;
        end
      end
      POINT: begin
        // A miss leaves dx unchanged, so it already points at the conceding side.
        ball_x_nx_s = CX;
        ball_y_nx_s = CY;
        dx_nx_s     = dx_r;
      end
      OVER: begin
        if (start) begin
          score_l_nx_s  = 4'd0;
          score_r_nx_s  = 4'd0;
          paddle_l_nx_s = PC;
          paddle_r_nx_s = PC;
        end else begin
          score_l_nx_s = score_l_r;
        end
      end
      default: begin
        cnt_nx_s = '0;
      end
    endcase
    game_over_nx_s = (state_nx_s == OVER);
  end

  // Game datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_x_r    <= CX;
      ball_y_r    <= CY;
      paddle_l_r  <= PC;
      paddle_r_r  <= PC;
      score_l_r   <= 4'd0;
      score_r_r   <= 4'd0;
      dx_r        <= 1'b1;
      dy_r        <= 1'b1;
      cnt_r       <= '0;
      game_over_r <= 1'b0;
    end else begin
      ball_x_r    <= ball_x_nx_s;
      ball_y_r    <= ball_y_nx_s;
      paddle_l_r  <= paddle_l_nx_s;
      paddle_r_r  <= paddle_r_nx_s;
      score_l_r   <= score_l_nx_s;
      score_r_r   <= score_r_nx_s;
      dx_r        <= dx_nx_s;
      dy_r        <= dy_nx_s;
      cnt_r       <= cnt_nx_s;
      game_over_r <= game_over_nx_s;
    end
  end

  assign ball_x    = ball_x_r;
  assign ball_y    = ball_y_r;
  assign paddle_l  = paddle_l_r;
  assign paddle_r  = paddle_r_r;
  assign score_l   = score_l_r;
  assign score_r   = score_r_r;
  assign state     = state_r;
  assign game_over = game_over_r;

endmodule

// File: tb/tb_pong_ctrl.sv
// Bench for pong_ctrl: directed openings plus randomized play compared every
// cycle against a plain-integer game model.
module tb_pong_ctrl;

  localparam int CX = (800 - 5) / 2;
  localparam int CY = (600 - 5) / 2;
  localparam int PC = (600 - 30) / 2;
  localparam int YMAX = 600 - 2 - 5;
  localparam int PMAX = 600 - 2 - 30;
  localparam int XMIN = 5;
  localparam int XMAX = 800 - 5 - 2 - 5;
  localparam int BSZ = 5;
  localparam int BST = 2;
  localparam int PLEN = 30;
  localparam int PST = 4;
  localparam int NSERVE = 60;
  localparam int WINS = 9;

  logic       clk = 1'b0;
  logic       rst, frame_tick, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic [9:0] ball_x, ball_y, paddle_l, paddle_r;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic       game_over;

  pong_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l(paddle_l), .paddle_r(paddle_r),
    .score_l(score_l), .score_r(score_r), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 serve, 2 play, 3 point, 4 over
  int m_state, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_dx, m_dy, m_cnt, m_conceder;
  int ev_hit_r, ev_miss_l, prev_state;
  int mode = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pad_move(input int p, input logic up, input logic dn);
    if (up && !dn) return (p - PST < 1) ? 1 : p - PST;
    if (dn && !up) return (p + PST > PMAX) ? PMAX : p + PST;
    return p;
  endfunction

  task automatic model_reset();
    m_state = 0; m_bx = CX; m_by = CY; m_pl = PC; m_pr = PC;
    m_sl = 0; m_sr = 0; m_dx = 1; m_dy = 1; m_cnt = 0; m_conceder = 0;
  endtask

  task automatic model_step(input logic ft, input logic st, input logic lu, input logic ld,
                            input logic ru, input logic rd);
    int ox, oy, opl, opr;
    ev_hit_r = 0;
    ev_miss_l = 0;
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        m_bx = CX; m_by = CY;
        if (ft) begin
          m_pl = pad_move(m_pl, lu, ld);
          m_pr = pad_move(m_pr, ru, rd);
          m_cnt++;
          if (m_cnt == NSERVE) begin m_cnt = 0; m_state = 2; end
        end
      end
      2: if (ft) begin
        ox = m_bx; oy = m_by; opl = m_pl; opr = m_pr;
        m_pl = pad_move(opl, lu, ld);
        m_pr = pad_move(opr, ru, rd);
        if (m_dy == 0 && oy < 1 + BST) begin m_by = 1; m_dy = 1; end
        else if (m_dy == 1 && oy + BST > YMAX) begin m_by = YMAX; m_dy = 0; end
        else m_by = (m_dy == 1) ? oy + BST : oy - BST;
        if (m_dx == 0 && ox < XMIN + BST) begin
          m_bx = XMIN;
          if (oy + BSZ >= opl && oy <= opl + PLEN) m_dx = 1;
          else begin
            m_sr = (m_sr + 1 > WINS) ? WINS : m_sr + 1;
            m_conceder = 0; m_state = 3; ev_miss_l = 1;
          end
        end else if (m_dx == 1 && ox + BST > XMAX) begin
          m_bx = XMAX;
          if (oy + BSZ >= opr && oy <= opr + PLEN) begin m_dx = 0; ev_hit_r = 1; end
          else begin
            m_sl = (m_sl + 1 > WINS) ? WINS : m_sl + 1;
            m_conceder = 1; m_state = 3;
          end
        end else m_bx = (m_dx == 1) ? ox + BST : ox - BST;
      end
      3: begin
        m_bx = CX; m_by = CY;
        m_dx = m_conceder;
        m_state = (m_sl == WINS || m_sr == WINS) ? 4 : 1;
      end
      4: if (st) begin
        m_sl = 0; m_sr = 0; m_pl = PC; m_pr = PC; m_state = 1;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_val("state", state, m_state);
    check_val("ball_x", ball_x, m_bx);
    check_val("ball_y", ball_y, m_by);
    check_val("paddle_l", paddle_l, m_pl);
    check_val("paddle_r", paddle_r, m_pr);
    check_val("score_l", score_l, m_sl);
    check_val("score_r", score_r, m_sr);
    check_val("game_over", game_over, (m_state == 4) ? 1 : 0);
  endtask

  // Drive one cycle from a negedge, advance the model, sample at the next negedge.
  task automatic run_cycle(input logic r, input logic ft, input logic st, input logic lu,
                           input logic ld, input logic ru, input logic rd);
    prev_state = m_state;
    rst = r; frame_tick = ft; start = st;
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
    if (r) begin
      model_reset();
      ev_hit_r = 0; ev_miss_l = 0;
    end else model_step(ft, st, lu, ld, ru, rd);
    @(negedge clk);
    compare_all();
    if (!r && prev_state == 3) begin
      check_val("point_recenter_x", ball_x, 397);
      check_val("point_recenter_y", ball_y, 297);
    end
    if (ev_hit_r != 0) check_val("right_hit_x", ball_x, 788);
    if (ev_miss_l != 0) begin
      check_val("left_miss_x", ball_x, 5);
      check_val("left_miss_point", state, 3);
    end
    if (m_state == 4) check_val("over_flag", game_over, 1);
  endtask

  task automatic check_reset_consts();
    check_val("rst_state", state, 0);
    check_val("rst_ball_x", ball_x, 397);
    check_val("rst_ball_y", ball_y, 297);
    check_val("rst_paddle_l", paddle_l, 285);
    check_val("rst_paddle_r", paddle_r, 285);
    check_val("rst_score_l", score_l, 0);
    check_val("rst_score_r", score_r, 0);
    check_val("rst_game_over", game_over, 0);
  endtask

  initial begin
    logic rnd_up, rnd_dn, t_up, t_dn, ft, st, r;
    int pc, bc, old_state;
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    rnd_up = 1'b0; rnd_dn = 1'b0;
    model_reset();
    @(negedge clk);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_consts();
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("idle_hold", state, 0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("start_to_serve", state, 1);

    // Serve countdown with idle cycles between ticks
    for (int i = 0; i < 60; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 58) check_val("serve_59", state, 1);
    end
    check_val("play_after_60", state, 2);
    check_val("serve_ball_x", ball_x, 397);
    check_val("serve_ball_y", ball_y, 297);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("first_move_x", ball_x, 399);
    check_val("first_move_y", ball_y, 299);

    // Left paddle driven up to the top limit, then both buttons pressed
    for (int i = 0; i < 71; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("paddle_top", paddle_l, 1);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("paddle_top_hold", paddle_l, 1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_val("both_btn_l", paddle_l, 1);
    check_val("both_btn_r", paddle_r, 285);

    // Randomized play: one side tracks the ball, the other wanders
    for (int i = 0; i < 40000; i++) begin
      ft = ($urandom_range(3) != 0);
      st = ($urandom_range(49) == 0);
      r  = ($urandom_range(14999) == 0);
      if ($urandom_range(15) == 0) begin
        rnd_up = 1'($urandom_range(1));
        rnd_dn = 1'($urandom_range(1));
      end
      pc = ((mode == 0) ? m_pr : m_pl) + 15;
      bc = m_by + 2;
      t_up = (pc > bc + 6);
      t_dn = (pc < bc - 6);
      old_state = m_state;
      if (mode == 0) run_cycle(r, ft, st, rnd_up, rnd_dn, t_up, t_dn);
      else           run_cycle(r, ft, st, t_up, t_dn, rnd_up, rnd_dn);
      if (old_state == 4 && m_state == 1) mode ^= 1;
    end

    // Reset in the middle of a rally
    for (int k = 0; k < 400 && m_state != 2; k++)
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("reach_play", state, 2);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_consts();
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("post_rst_idle", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
